ahb_periph_bridge: RTL
======================

# ahb_periph_bridge

AHB-Lite subordinate that acts as the initiator for the simple byte-strobed peripheral port used by our memory-mapped peripherals (timer, GPIO, etc.). It converts AHB address/data phases into the peripheral write signals (`addrIn`, `sizeDecode`, `dataIn`) and the registered-read signals (`addrOut` → `dataOut`). It returns read data with one wait state and answers illegal transfers with an AHB ERROR response. One instance sits between the AHB decoder and each peripheral.

## Interface
Parameters:
- `AW`, default 8: peripheral word-address width; maps to `HADDR[AW+1:2]`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `HSEL`  in  1  subordinate select.
- `HADDR`  in  32  byte address.
- `HTRANS`  in  2  transfer type; `HTRANS[1]`=1 means NONSEQ/SEQ.
- `HSIZE`  in  3  0=byte, 1=half, 2=word.
- `HWRITE`  in  1  1=write.
- `HWDATA`  in  32  write data (data phase).
- `HREADY`  in  1  bus ready from interconnect.
- `HREADYOUT`  out  1  this subordinate ready.
- `HRESP`  out  1  0=OKAY, 1=ERROR.
- `HRDATA`  out  32  read data.
- `addrIn`  out  AW  peripheral write word address.
- `addrOut`  out  AW  peripheral read word address.
- `sizeDecode`  out  4  byte write strobes; bit n writes byte lane n.
- `dataIn`  out  32  peripheral write data.
- `dataOut`  in  32  peripheral read data, valid one cycle after `addrOut`.

## Operation
- Accept = `HSEL & HREADY & HTRANS[1]`, sampled in the address phase.
- Lane strobes: byte → `4'b0001 << HADDR[1:0]`; half → `HADDR[1] ? 4'b1100 : 4'b0011`; word → `4'b1111`.
- States: IDLE, WRITE, RD_WAIT, RD_DATA, ERR1, ERR2.
- IDLE: `HREADYOUT`=1. On a legal write accept, register `addrIn`=`HADDR[AW+1:2]` and the strobes, then go to WRITE. On a legal read accept, register `addrOut`, then go to RD_WAIT. On an illegal accept, go to ERR1. Otherwise stay in IDLE.
- WRITE (data phase): `sizeDecode` = registered strobes; `dataIn` = `HWDATA` passed through combinationally; `HREADYOUT`=1. The peripheral commits on this cycle's closing edge. A new accept in the same cycle is decoded exactly as in IDLE (back-to-back transfers). With no accept, go to IDLE.
- RD_WAIT: `HREADYOUT`=0; the peripheral registers `dataOut`. Go to RD_DATA.
- RD_DATA: `HRDATA`=`dataOut`, `HREADYOUT`=1. Accepts are handled as in IDLE.
- `HRDATA`=0 and `sizeDecode`=0 in every state except RD_DATA and WRITE respectively. `dataIn`=0 outside WRITE.
- `addrIn` and `addrOut` hold their last value between transfers.
- Reads never produce a strobe. Writes never alter `addrOut`.

## Timing
- Reset values: `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, `addrIn`=0, `addrOut`=0, `sizeDecode`=0, `dataIn`=0; state IDLE.
- Write: 0 wait states. `sizeDecode` is nonzero for exactly one cycle per write.
- Read: 1 wait state. The data phase is 2 cycles.
- Read-after-write to the same word: the write commits at the end of WRITE, before the peripheral samples `addrOut` at the end of RD_WAIT, so the new value is returned.
- ERR1: `HREADYOUT`=0, `HRESP`=1. ERR2: `HREADYOUT`=1, `HRESP`=1; accepts are handled as in IDLE. This is the standard two-cycle AHB error.
- Reset mid-transfer: return to IDLE immediately; `sizeDecode` drops to 0 asynchronously, so no partial write occurs.
- Accept while `HTRANS` is IDLE/BUSY, or while `HSEL`=0: no state change and no strobes.

## Configuration
- `BRIDGE_ALIGN_CHECK_EN` defined: an accept is illegal, and receives the ERR1/ERR2 response with no peripheral access, if `HSIZE`>2, or `HSIZE`=1 with `HADDR[0]`=1, or `HSIZE`=2 with `HADDR[1:0]`≠0.
- `BRIDGE_ALIGN_CHECK_EN` undefined: no transfer is illegal. `HSIZE`>2 is treated as a word access. Misaligned half-word and word accesses ignore the low address bits and use the lane strobes above. ERR states are unreachable and `HRESP` is tied to 0.

## Test plan
- Reset, then a word write to `HADDR`=0x0000_0008 with `HWDATA`=0xDEADBEEF → one cycle with `addrIn`=2, `sizeDecode`=4'b1111, `dataIn`=0xDEADBEEF; `HREADYOUT` stays 1.
- Byte write to 0x0000_0006 with `HWDATA`=0x00AB0000 → `sizeDecode`=4'b0100, `addrIn`=1. Half-word write to 0x0000_0006 → `sizeDecode`=4'b1100.
- Read of 0x0000_000C with a peripheral model returning 0x12345678 → `addrOut`=3; `HREADYOUT` low for one cycle, then `HRDATA`=0x12345678 with `HREADYOUT`=1.
- Back-to-back write 0x55 to word 4, then read word 4 (read address phase coincides with the write data phase) → the read returns 0x55 after one wait state.
- With `BRIDGE_ALIGN_CHECK_EN`: word write to 0x0000_0002 → ERR1 then ERR2 (`HRESP`=1 for both cycles, `HREADYOUT` 0 then 1) and `sizeDecode` stays 0. Without the macro, the same write gives `sizeDecode`=4'b1111 and `addrIn`=0.
- Assert `rstn` low during RD_WAIT → all outputs return to reset values; after release the next read completes normally.

Source files
------------

// File: rtl/ahb_periph_bridge.sv
// ahb_periph_bridge: AHB-Lite subordinate that drives a simple byte-strobed
// peripheral port. Writes have zero wait states; reads have one wait state.
// Optional feature macro: BRIDGE_ALIGN_CHECK_EN. When it is defined, oversized
// and misaligned transfers get a two-cycle ERROR response and do not touch
// the peripheral. When it is undefined, every transfer is legal and HRESP is 0.
module ahb_periph_bridge #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] addrIn,
  output logic [AW-1:0] addrOut,
  output logic [3:0]    sizeDecode,
  output logic [31:0]   dataIn,
  input  logic [31:0]   dataOut
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_ERR1    = 3'd4;
  localparam logic [2:0] ST_ERR2    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_in_q, addr_in_d;
  logic [AW-1:0] addr_out_q, addr_out_d;
  logic [3:0]    strb_q, strb_d;
  logic          accept_s;
  logic          illegal_s;
  logic          unused_s;

  // Byte-lane strobes for a transfer. Sizes above a half-word select all
  // four lanes; misaligned halves and words ignore the low address bits.
  function automatic logic [3:0] lane_strobes(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      3'd0:    strb = 4'b0001 << addr_lo;
      3'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Upper address bits and HTRANS[0] (SEQ vs NONSEQ) do not affect the bridge.
  assign unused_s = ^{HADDR[31:AW+2], HTRANS[0]};

  assign accept_s = HSEL & HREADY & HTRANS[1];

`ifdef BRIDGE_ALIGN_CHECK_EN
  assign illegal_s = (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
  assign illegal_s = 1'b0;
`endif

  // Next-state decode; accepts are decoded identically in every state
  // that presents HREADYOUT=1, giving back-to-back transfers.
  always_comb begin
    state_d    = state_q;
    addr_in_d  = addr_in_q;
    addr_out_d = addr_out_q;
    strb_d     = strb_q;
    case (state_q)
      ST_RD_WAIT: state_d = ST_RD_DATA;
      ST_ERR1:    state_d = ST_ERR2;
      ST_IDLE, ST_WRITE, ST_RD_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_d = ST_ERR1;
          end else if (HWRITE) begin
            state_d   = ST_WRITE;
            addr_in_d = HADDR[AW+1:2];
            strb_d    = lane_strobes(HSIZE, HADDR[1:0]);
          end else begin
            state_d    = ST_RD_WAIT;
            addr_out_d = HADDR[AW+1:2];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and address/strobe registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      addr_in_q  <= '0;
      addr_out_q <= '0;
      strb_q     <= 4'b0000;
    end else begin
      state_q    <= state_d;
      addr_in_q  <= addr_in_d;
      addr_out_q <= addr_out_d;
      strb_q     <= strb_d;
    end
  end

  assign addrIn  = addr_in_q;
  assign addrOut = addr_out_q;

  // Bus handshake: stall only during the read wait and the first error cycle.
  always_comb begin
    if ((state_q == ST_RD_WAIT) || (state_q == ST_ERR1)) begin
      HREADYOUT = 1'b0;
    end else begin
      HREADYOUT = 1'b1;
    end
  end

`ifdef BRIDGE_ALIGN_CHECK_EN
  // ERROR response across both error cycles.
  always_comb begin
    if ((state_q == ST_ERR1) || (state_q == ST_ERR2)) begin
      HRESP = 1'b1;
    end else begin
      HRESP = 1'b0;
    end
  end
`else
  assign HRESP = 1'b0;
`endif

  // Peripheral write port: strobes and write data only in the write data
  // phase; state resets asynchronously so a reset cancels a pending write.
  always_comb begin
    if (state_q == ST_WRITE) begin
      sizeDecode = strb_q;
      dataIn     = HWDATA;
    end else begin
      sizeDecode = 4'b0000;
      dataIn     = 32'h0000_0000;
    end
  end

  // Read data is forwarded from the peripheral register in the last read cycle.
  always_comb begin
    if (state_q == ST_RD_DATA) begin
      HRDATA = dataOut;
    end else begin
      HRDATA = 32'h0000_0000;
    end
  end

endmodule
